// File: rtl/enable_demux_1_to_2_buf.sv
// Enabled 1-to-2 demultiplexer with a single-entry holding register, a valid/ready
// handshake and a wrapping transfer counter on each output channel.
module enable_demux_1_to_2_buf #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic [1:0]        ready_vec;
  logic [1:0]        sel_vec;
  logic [1:0]        valid_vec;
  logic [1:0]        load;
  logic [1:0]        drain;
  logic [DATA_W-1:0] data_vec [2];
  logic [CNT_W-1:0]  cnt_vec  [2];
  logic              accept;

  assign ready_vec = {out1_ready, out0_ready};
  assign sel_vec   = {sel, ~sel};

  // Only the selected channel can stall the input; a blocked sibling never does.
  assign in_ready = en & (sel ? (~valid_vec[1] | out1_ready)
                              : (~valid_vec[0] | out0_ready));
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;
      logic [CNT_W-1:0]  cnt_reg;

      assign load[gi]      = accept & sel_vec[gi];
      assign drain[gi]     = valid_reg & ready_vec[gi];
      assign valid_vec[gi] = valid_reg;
      assign data_vec[gi]  = data_reg;
      assign cnt_vec[gi]   = cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          cnt_reg   <= '0;
        end else begin
          // A load on the same edge as a drain keeps the slot full.
          if (load[gi]) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
          end else if (drain[gi]) begin
            valid_reg <= 1'b0;
          end
          if (drain[gi]) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign out0_valid = valid_vec[0];
  assign out1_valid = valid_vec[1];
  assign out0_data  = data_vec[0];
  assign out1_data  = data_vec[1];
  assign cnt0       = cnt_vec[0];
  assign cnt1       = cnt_vec[1];

endmodule

// File: tb/tb_enable_demux_1_to_2_buf.sv
// Scoreboard bench: the driver queues each word it expects accepted, a negedge
// monitor pops and compares on every output handshake.
module tb_enable_demux_1_to_2_buf;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              sel = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_valid;
  logic              out0_ready = 1'b0;
  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready = 1'b0;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];

  enable_demux_1_to_2_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen before the edge must deliver the oldest queued word.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL ch0_unexpected: got 0x%0h expected none at %0t", out0_data, $time);
        end else begin
          check("ch0_data", 32'(out0_data), 32'(q0.pop_front()));
          $display("ch0 transfer data=0x%02h t=%0t", out0_data, $time);
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL ch1_unexpected: got 0x%0h expected none at %0t", out1_data, $time);
        end else begin
          check("ch1_data", 32'(out1_data), 32'(q1.pop_front()));
          $display("ch1 transfer data=0x%02h t=%0t", out1_data, $time);
        end
      end
    end
  end

  // One cycle of stimulus; inputs change just after posedge, in_ready checked at negedge.
  task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d,
                      input logic r0, input logic r1, input logic exp_rdy);
    in_valid = v; sel = s; en = e; in_data = d; out0_ready = r0; out1_ready = r1;
    @(negedge clk);
    if (v) begin
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (exp_rdy) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_out0_valid"}, 32'(out0_valid), 32'd0);
    check({tag, "_out1_valid"}, 32'(out1_valid), 32'd0);
    check({tag, "_out0_data"},  32'(out0_data),  32'd0);
    check({tag, "_out1_data"},  32'(out1_data),  32'd0);
    check({tag, "_cnt0"},       32'(cnt0),       32'd0);
    check({tag, "_cnt1"},       32'(cnt1),       32'd0);
  endtask

  task automatic reset_dut(input int cycles);
    rst = 1'b1; in_valid = 1'b1; en = 1'b1; sel = 1'b0; in_data = 8'hEE;
    out0_ready = 1'b1; out1_ready = 1'b1;
    q0.delete(); q1.delete();
    repeat (cycles) @(posedge clk);
    #1;
    check_clear("reset");
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
    check({tag, "_q1_left"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    // Reset with in_valid held high: nothing may load.
    reset_dut(2);

    // Basic routing
    step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    check("basic_out0_valid", 32'(out0_valid), 32'd1);
    check("basic_out0_data",  32'(out0_data),  32'hA5);
    step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    check("basic_out0_valid_drop", 32'(out0_valid), 32'd0);
    check("basic_out1_data", 32'(out1_data), 32'h3C);
    idle(1);
    check("basic_cnt0", 32'(cnt0), 32'd1);
    check("basic_cnt1", 32'(cnt1), 32'd1);
    check_drained("basic");

    // Enable gating
    reset_dut(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
      check("gate_out0_valid", 32'(out0_valid), 32'd0);
    end
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    check("gate_out0_data", 32'(out0_data), 32'h55);
    idle(1);
    check("gate_cnt0", 32'(cnt0), 32'd1);
    check_drained("gate");

    // Backpressure on ch0 must not block ch1
    reset_dut(1);
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    check("bp_hold_data", 32'(out0_data), 32'h11);
    step(1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    check("bp_hold_valid", 32'(out0_valid), 32'd1);
    check("bp_hold_data2", 32'(out0_data), 32'h11);
    step(1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
    check("bp_refill_valid", 32'(out0_valid), 32'd1);
    check("bp_refill_data",  32'(out0_data),  32'h22);
    idle(1);
    check("bp_cnt0", 32'(cnt0), 32'd2);
    check("bp_cnt1", 32'(cnt1), 32'd1);
    check_drained("bp");

    // Streaming, alternating channels
    reset_dut(1);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'(i % 2), 1'b1, 8'(8'h40 + i), 1'b1, 1'b1, 1'b1);
    idle(1);
    check("stream_cnt0", 32'(cnt0), 32'd10);
    check("stream_cnt1", 32'(cnt1), 32'd10);
    check_drained("stream");

    // Counter wrap on ch1, then reset while ch0 holds a word
    reset_dut(1);
    for (int i = 0; i < 17; i++)
      step(1'b1, 1'b1, 1'b1, 8'(8'h80 + i), 1'b1, 1'b1, 1'b1);
    idle(1);
    check("wrap_cnt1", 32'(cnt1), 32'd1);
    check_drained("wrap");
    step(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    check("midrst_loaded", 32'(out0_valid), 32'd1);
    reset_dut(1);
    idle(2);
    check("post_rst_out0_valid", 32'(out0_valid), 32'd0);
    check("post_rst_cnt0", 32'(cnt0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
